// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch / load-store memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        LS_WAIT = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    // Request as presented on the shared memory port.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_req_t;

    // Fetches are always reads with no write payload.
    function automatic mem_req_t fetch_req(input logic [31:0] addr);
        mem_req_t r;
        r      = '0;
        r.addr = addr;
        return r;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Wait-state counter: counts memory stall cycles and flags the TIMEOUT-th one.
module mem_arb_timer
#(
    parameter int TIMEOUT = 16
)
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count stalled cycles; saturate so a stuck enable cannot wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CW'(TIMEOUT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High in the stalled cycle that brings the count up to TIMEOUT.
    assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and load/store.
// Load/store has priority, bounded to LS_BURST back-to-back grants while a
// fetch waits. Stalled accesses are aborted after TIMEOUT wait cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT  = 16,
    parameter int LS_BURST = 4
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_wmask,
    output logic        ls_ack,
    output logic [31:0] ls_rdata,
    output logic        err,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        fault
);

    localparam int BW = $clog2(LS_BURST + 1);

    arb_state_e    state_q, state_d;
    owner_e        own_q, own_d;
    mem_req_t      req_q, req_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          mem_valid_q, mem_valid_d;
    logic [31:0]   data_q, data_d;
    logic          abort_q, abort_d;
    logic          fault_q, fault_d;
    logic          if_ack_q, if_ack_d;
    logic          ls_ack_q, ls_ack_d;
    logic          err_q, err_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   ls_rdata_q, ls_rdata_d;

    logic in_wait, ack_busy, grant_ls, grant_if;
    logic tmr_clear, tmr_en, tmr_expired;

    // The ack cycle still shows the finished request's req high (it drops one
    // cycle later), so no grant is made while any ack is on the outputs.
    assign in_wait  = (state_q == IF_WAIT) || (state_q == LS_WAIT);
    assign ack_busy = if_ack_q || ls_ack_q;
    assign grant_ls = (state_q == IDLE) && !ack_busy && ls_req &&
                      ((burst_q < BW'(LS_BURST)) || !if_req);
    assign grant_if = (state_q == IDLE) && !ack_busy && !grant_ls && if_req;

    // Timer restarts on every grant and counts only stalled wait cycles, so
    // mem_ready on the final cycle wins over the abort.
    assign tmr_clear = grant_ls || grant_if;
    assign tmr_en    = in_wait && !mem_ready;

    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_ls) begin
                    state_d = LS_WAIT;
                end else if (grant_if) begin
                    state_d = IF_WAIT;
                end
            end
            IF_WAIT, LS_WAIT: begin
                if (mem_ready || tmr_expired) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values; everything visible outside is a flop.
    always_comb begin
        own_d       = own_q;
        req_d       = req_q;
        mem_valid_d = mem_valid_q;
        data_d      = data_q;
        abort_d     = abort_q;
        fault_d     = fault_q;
        burst_d     = burst_q;
        if_ack_d    = 1'b0;
        ls_ack_d    = 1'b0;
        err_d       = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;

        // A burst only counts while fetch is actually waiting.
        if (!if_req) begin
            burst_d = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (grant_ls) begin
                    own_d       = OWN_LS;
                    req_d.we    = ls_we;
                    req_d.addr  = ls_addr;
                    req_d.wdata = ls_wdata;
                    req_d.wmask = ls_wmask;
                    mem_valid_d = 1'b1;
                    burst_d     = if_req ? burst_q + 1'b1 : '0;
                end else if (grant_if) begin
                    own_d       = OWN_IF;
                    req_d       = fetch_req(if_addr);
                    mem_valid_d = 1'b1;
                    burst_d     = '0;
                end
            end
            IF_WAIT, LS_WAIT: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    data_d      = mem_rdata;
                    abort_d     = 1'b0;
                end else if (tmr_expired) begin
                    mem_valid_d = 1'b0;
                    data_d      = '0;
                    abort_d     = 1'b1;
                    fault_d     = 1'b1;
                end
            end
            RESP: begin
                err_d = abort_q;
                if (own_q == OWN_LS) begin
                    ls_ack_d   = 1'b1;
                    ls_rdata_d = data_q;
                end else begin
                    if_ack_d   = 1'b1;
                    if_rdata_d = data_q;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            own_q       <= OWN_IF;
            req_q       <= '0;
            burst_q     <= '0;
            mem_valid_q <= 1'b0;
            data_q      <= '0;
            abort_q     <= 1'b0;
            fault_q     <= 1'b0;
            if_ack_q    <= 1'b0;
            ls_ack_q    <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            own_q       <= own_d;
            req_q       <= req_d;
            burst_q     <= burst_d;
            mem_valid_q <= mem_valid_d;
            data_q      <= data_d;
            abort_q     <= abort_d;
            fault_q     <= fault_d;
            if_ack_q    <= if_ack_d;
            ls_ack_q    <= ls_ack_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_addr  = req_q.addr;
    assign mem_we    = req_q.we;
    assign mem_wdata = req_q.wdata;
    assign mem_wmask = req_q.wmask;
    assign if_ack    = if_ack_q;
    assign ls_ack    = ls_ack_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign err       = err_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a memory responder predicts each grant
// and its response, a monitor compares every ack against the prediction.
module tb_mem_arbiter;

    localparam int TIMEOUT  = 16;
    localparam int LS_BURST = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [3:0]  ls_wmask;
    logic        if_ack, ls_ack, err, fault;
    logic [31:0] if_rdata, ls_rdata;
    logic        mem_valid, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TIMEOUT), .LS_BURST(LS_BURST)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_wmask(ls_wmask), .ls_ack(ls_ack), .ls_rdata(ls_rdata), .err(err),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .fault(fault)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t if_q[$];
    exp_t ls_q[$];
    bit   ack_order[$];     // 0 = fetch ack, 1 = load/store ack
    int   checks = 0;
    int   failures = 0;
    int   fixed_lat = 0;    // memory wait cycles before ready; -1 = random
    bit   model_fault = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents as seen by the bench.
    function automatic logic [31:0] rd(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    function automatic int pack_order();
        int v = 0;
        foreach (ack_order[i]) v = v * 2 + int'(ack_order[i]);
        return (ack_order.size() << 16) | v;
    endfunction

    // Memory responder + grant predictor. A grant is seen as the first cycle
    // of a new mem_valid; the requests it was decided on are last cycle's.
    initial begin
        bit          busy = 0, if_prev = 0, ls_prev = 0, exp_ls;
        int          lat = 0, wcnt = 0, ls_run = 0;
        logic [31:0] cur_addr = '0;
        exp_t        e;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy = 0; ls_run = 0; if_prev = 0; ls_prev = 0;
                mem_ready = 1'b0; mem_rdata = '0;
            end else begin
                if (mem_valid && !busy) begin
                    exp_ls = ls_prev && (ls_run < LS_BURST || !if_prev);
                    if (exp_ls) begin
                        chk("ls_grant_we_addr", {mem_we, mem_addr}, {ls_we, ls_addr});
                        chk("ls_grant_mask_data", {mem_wmask, mem_wdata}, {ls_wmask, ls_wdata});
                        ls_run = if_prev ? ls_run + 1 : 0;
                    end else begin
                        chk("if_grant_we_addr", {mem_we, mem_addr}, {1'b0, if_addr});
                        ls_run = 0;
                    end
                    if (fixed_lat >= 0) lat = fixed_lat;
                    else if ($urandom_range(0, 9) < 7) lat = $urandom_range(0, 4);
                    else lat = $urandom_range(TIMEOUT - 3, TIMEOUT + 2);
                    busy = 1; wcnt = 0; cur_addr = mem_addr;
                    e.err   = (lat >= TIMEOUT);
                    e.rdata = e.err ? 32'h0 : rd(mem_addr);
                    if (e.err) model_fault = 1'b1;
                    if (exp_ls) ls_q.push_back(e);
                    else        if_q.push_back(e);
                end else if (mem_valid) begin
                    chk("mem_addr_stable", mem_addr, cur_addr);
                end
                if (!mem_valid) busy = 0;
                if (!if_req) ls_run = 0;
                if (busy) begin
                    mem_ready = (wcnt == lat);
                    mem_rdata = mem_ready ? rd(cur_addr) : $urandom;
                    wcnt++;
                end else begin
                    // Ready outside an access is noise the arbiter must ignore.
                    mem_ready = 1'($urandom_range(0, 1));
                    mem_rdata = $urandom;
                end
                if_prev = if_req;
                ls_prev = ls_req;
            end
        end
    end

    // Monitor: every ack is matched against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (if_ack || ls_ack)) begin
                chk("ack_onehot", 64'(if_ack & ls_ack), 64'h0);
                if (if_ack) begin
                    ack_order.push_back(1'b0);
                    if (if_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL if_ack_unexpected: got ack expected none at %0t", $time);
                    end else begin
                        e = if_q.pop_front();
                        chk("if_rdata", if_rdata, e.rdata);
                        chk("if_err", err, e.err);
                        chk("if_fault", fault, model_fault);
                    end
                end
                if (ls_ack) begin
                    ack_order.push_back(1'b1);
                    if (ls_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL ls_ack_unexpected: got ack expected none at %0t", $time);
                    end else begin
                        e = ls_q.pop_front();
                        chk("ls_rdata", ls_rdata, e.rdata);
                        chk("ls_err", err, e.err);
                        chk("ls_fault", fault, model_fault);
                    end
                end
            end
        end
    end

    // Fetch transaction; entered and left just after a rising edge.
    task automatic if_txn(input logic [31:0] a, output int lat, output int vfirst, output int vcnt);
        if_addr = a; if_req = 1'b1;
        lat = -1; vfirst = -1; vcnt = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (mem_valid) begin
                vcnt++;
                if (vfirst < 0) vfirst = c;
            end
            if (if_ack) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) begin
            checks++; failures++;
            $display("FAIL if_ack_timeout: got no ack expected ack within 300 cycles");
        end
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    // Load/store transaction; entered and left just after a rising edge.
    task automatic ls_txn(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
        bit done = 0;
        ls_we = we; ls_addr = a; ls_wdata = wd; ls_wmask = wm; ls_req = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (ls_ack) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL ls_ack_timeout: got no ack expected ack within 300 cycles");
        end
        @(posedge clk); #1;
        ls_req = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end expected end of test");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int l0, f0, v0, l1, f1, v1;
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {mem_valid, if_ack, ls_ack, err, fault, mem_we, mem_wmask}, 64'h0);
        chk("reset_rdata", {if_rdata, ls_rdata}, 64'h0);
        chk("reset_mem_bus", {mem_addr, mem_wdata}, 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Zero-wait fetch: valid one cycle after the request, ack two later.
        fixed_lat = 0;
        if_txn(32'h100, l0, f0, v0);
        chk("if_first_valid_cycle", f0, 1);
        chk("if_ack_latency", l0, 3);

        // Simultaneous requests: load/store goes first.
        ack_order.delete();
        fork
            if_txn(32'h180, l0, f0, v0);
            ls_txn(1'b1, 32'h200, 32'h55, 4'hF);
        join
        chk("both_req_order", pack_order(), (2 << 16) | 2'b10);

        // Continuous load/store against a waiting fetch: 4 LS, 1 IF, LS again.
        ack_order.delete();
        fork
            if_txn(32'h300, l0, f0, v0);
            for (int i = 0; i < 6; i++)
                ls_txn(1'($urandom_range(0, 1)), 32'h400 + 32'(i * 4), $urandom, 4'($urandom));
        join
        chk("burst_order", pack_order(), (7 << 16) | 7'b1111011);

        // Ready on the last allowed wait cycle completes normally.
        fixed_lat = TIMEOUT - 1;
        if_txn(32'h500, l0, f0, v0);
        chk("last_cycle_valid_cnt", v0, TIMEOUT);
        chk("last_cycle_latency", l0, TIMEOUT + 2);
        chk("last_cycle_fault", fault, 1'b0);

        // Never ready: abort after TIMEOUT wait cycles, fault sticks.
        fixed_lat = TIMEOUT + 4;
        if_txn(32'h600, l1, f1, v1);
        chk("timeout_valid_cnt", v1, TIMEOUT);
        chk("timeout_latency", l1, TIMEOUT + 2);
        repeat (3) @(negedge clk);
        chk("fault_sticky_idle", fault, 1'b1);
        @(posedge clk); #1;
        fixed_lat = 2;
        ls_txn(1'b0, 32'h640, 32'h0, 4'h0);
        chk("fault_sticky_after_ok", fault, 1'b1);

        // Reset in the middle of a load/store wait.
        fixed_lat = TIMEOUT + 4;
        ls_we = 1'b1; ls_addr = 32'h680; ls_wdata = 32'hA5; ls_wmask = 4'h3; ls_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_valid) break;
        end
        chk("pre_reset_valid", mem_valid, 1'b1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset_ctrl", {mem_valid, if_ack, ls_ack, err, fault, mem_we, mem_wmask}, 64'h0);
        chk("midreset_mem_bus", {mem_addr, mem_wdata}, 64'h0);
        ls_req = 1'b0;
        if_q.delete(); ls_q.delete();
        model_fault = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        fixed_lat = 1;
        if_txn(32'h700, l0, f0, v0);
        chk("post_reset_latency", l0, 4);
        chk("post_reset_fault", fault, 1'b0);

        // Random traffic from both requesters with random memory latency.
        fixed_lat = -1;
        fork
            begin
                int l, f, v, g;
                for (int i = 0; i < 40; i++) begin
                    g = $urandom_range(0, 2);
                    if (g > 0) begin
                        repeat (g) @(posedge clk);
                        #1;
                    end
                    if_txn({1'b0, 31'($urandom)}, l, f, v);
                end
            end
            begin
                int g;
                for (int i = 0; i < 40; i++) begin
                    g = $urandom_range(0, 2);
                    if (g > 0) begin
                        repeat (g) @(posedge clk);
                        #1;
                    end
                    ls_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
                end
            end
        join
        repeat (10) @(negedge clk);
        chk("queues_drained", 64'(if_q.size() + ls_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
